opti_iir_top: RTL and testbench

Fixed-point 4th-order IIR low-latency filter block for the `opti_top` datapath: two cascaded direct-form-I biquad sections process a 16-bit signed sample stream qualified by a valid strobe. The block sits between the sample source (ADC front end / test source) and downstream consumers. It produces one filtered 16-bit sample per accepted input, with a fixed 3-cycle latency.

---
 rtl/opti_pkg.sv | 20 ++
 rtl/opti_biquad.sv | 41 ++++
 rtl/opti_iir_top.sv | 39 +++
 tb/tb_opti_iir_top.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/opti_pkg.sv
// opti_pkg: sample/coefficient types, accumulator width, rounding constants and 16-bit reduction.
// Define OPTI_SAT_EN for saturating reduction; otherwise results wrap.
package opti_pkg;
    typedef logic signed [15:0] sample_t;
    typedef logic signed [15:0] coef_t;
    localparam int ACC_W = 36;
    typedef logic signed [ACC_W-1:0] acc_t;
    localparam int COEF_FRAC = 14;
    localparam int ROUND_CONST = 2**13;
    function automatic acc_t mul(input coef_t c, input sample_t s);
        return acc_t'(c) * acc_t'(s);
    endfunction
    function automatic sample_t reduce16(input acc_t s);
`ifdef OPTI_SAT_EN
        return (s > 36'sd32767) ? 16'sh7fff : (s < -36'sd32768) ? 16'sh8000 : sample_t'(s);
`else
        return sample_t'(s);
`endif
    endfunction
endpackage

// File: rtl/opti_biquad.sv
// opti_biquad: direct-form-I biquad section, combinational MAC into a registered output.
// Reduction mode follows OPTI_SAT_EN through opti_pkg::reduce16.
module opti_biquad import opti_pkg::*; #(
    parameter coef_t B0 = 16'sd16384,
    parameter coef_t B1 = '0,
    parameter coef_t B2 = '0,
    parameter coef_t A1 = '0,
    parameter coef_t A2 = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] x,
    input  logic               x_valid,
    output logic signed [15:0] y,
    output logic               y_valid
);
    logic signed [15:0] x1, x2, y2, y_next;
    acc_t acc;
    // The output register doubles as y[n-1], keeping the feedback loop one register deep.
    always_comb begin
        acc = mul(B0, x) + mul(B1, x1) + mul(B2, x2) - mul(A1, y) - mul(A2, y2) + acc_t'(ROUND_CONST);
        y_next = reduce16(acc >>> COEF_FRAC);
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x1 <= '0;
            x2 <= '0;
            y2 <= '0;
            y <= '0;
            y_valid <= 1'b0;
        end else begin
            y_valid <= x_valid;
            if (x_valid) begin
                x1 <= x;
                x2 <= x1;
                y2 <= y;
                y <= y_next;
            end
        end
    end
endmodule

// File: rtl/opti_iir_top.sv
// opti_iir_top: 4th-order IIR as an input register plus two cascaded biquads, latency 3.
// OPTI_SAT_EN selects saturating section outputs; default wraps.
module opti_iir_top import opti_pkg::*; #(
    parameter coef_t S1_B0 = 16'sd16384,
    parameter coef_t S1_B1 = '0,
    parameter coef_t S1_B2 = '0,
    parameter coef_t S1_A1 = '0,
    parameter coef_t S1_A2 = '0,
    parameter coef_t S2_B0 = 16'sd16384,
    parameter coef_t S2_B1 = '0,
    parameter coef_t S2_B2 = '0,
    parameter coef_t S2_A1 = '0,
    parameter coef_t S2_A2 = '0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic signed [15:0] data_in,
    input  logic               valid_in,
    output logic signed [15:0] data_out,
    output logic               valid_out
);
    logic signed [15:0] in_r, s1_y;
    logic in_v, s1_v;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_r <= '0;
            in_v <= 1'b0;
        end else begin
            in_v <= valid_in;
            if (valid_in) in_r <= data_in;
        end
    end
    opti_biquad #(.B0(S1_B0), .B1(S1_B1), .B2(S1_B2), .A1(S1_A1), .A2(S1_A2)) u_s1 (
        .clk(clk), .rst(rst), .x(in_r), .x_valid(in_v), .y(s1_y), .y_valid(s1_v)
    );
    opti_biquad #(.B0(S2_B0), .B1(S2_B1), .B2(S2_B2), .A1(S2_A1), .A2(S2_A2)) u_s2 (
        .clk(clk), .rst(rst), .x(s1_y), .x_valid(s1_v), .y(data_out), .y_valid(valid_out)
    );
endmodule

// File: tb/tb_opti_iir_top.sv
// tb_opti_iir_top: three filter configurations (identity, recursive, overflow) on one stimulus stream,
// checked against an integer reference model through per-instance expected-value queues.
module tb_opti_iir_top;
    typedef struct {
        int val;
        int edge_n;
    } exp_t;
    logic clk = 1'b0;
    logic rst = 1'b0;
    logic signed [15:0] data_in = '0;
    logic valid_in = 1'b0;
    logic signed [15:0] dout [3];
    logic vout [3];
    exp_t q [3][$];
    int n_chk = 0;
    int n_err = 0;
    int ecnt = 0;
    int cb0 [3] = '{16384, 16384, 32767};
    int cb1 [3] = '{0, 0, 0};
    int cb2 [3] = '{0, 0, 0};
    int ca1 [3] = '{0, -8192, 0};
    int ca2 [3] = '{0, 0, 0};
    longint mx1 [3], mx2 [3], my1 [3], my2 [3];

    opti_iir_top u_id (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(dout[0]), .valid_out(vout[0])
    );
    opti_iir_top #(.S1_A1(-16'sd8192)) u_rec (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(dout[1]), .valid_out(vout[1])
    );
    opti_iir_top #(.S1_B0(16'sd32767)) u_ovf (
        .clk(clk), .rst(rst), .data_in(data_in), .valid_in(valid_in),
        .data_out(dout[2]), .valid_out(vout[2])
    );

    always #5 clk = ~clk;
    always @(posedge clk) ecnt <= ecnt + 1;

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: one section with the given coefficients, then an identity section (a no-op).
    function automatic int model(input int d, input int x);
        longint acc, s;
        int r;
        acc = cb0[d] * longint'(x) + cb1[d] * mx1[d] + cb2[d] * mx2[d] - ca1[d] * my1[d] - ca2[d] * my2[d];
        s = (acc + 8192) >>> 14;
`ifdef OPTI_SAT_EN
        r = (s > 32767) ? 32767 : (s < -32768) ? -32768 : int'(s);
`else
        r = int'(s & 64'hffff);
        if (r > 32767) r -= 65536;
`endif
        mx2[d] = mx1[d];
        mx1[d] = x;
        my2[d] = my1[d];
        my1[d] = r;
        return r;
    endfunction

    task automatic send(input int x);
        @(posedge clk);
        #1;
        data_in = 16'(x);
        valid_in = 1'b1;
        for (int d = 0; d < 3; d++) q[d].push_back('{model(d, x), ecnt});
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            valid_in = 1'b0;
        end
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while (q[0].size() + q[1].size() + q[2].size() != 0 && t < 20) begin
            @(posedge clk);
            t++;
        end
        chk("drain_left", q[0].size() + q[1].size() + q[2].size(), 0);
    endtask

    task automatic do_reset(input int cyc);
        rst = 1'b1;
        valid_in = 1'b0;
        for (int d = 0; d < 3; d++) begin
            q[d].delete();
            mx1[d] = 0;
            mx2[d] = 0;
            my1[d] = 0;
            my2[d] = 0;
        end
        repeat (cyc) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < 3; d++) begin
                if (vout[d]) begin
                    if (q[d].size() == 0) chk($sformatf("spurious_vout%0d", d), 1, 0);
                    else begin
                        e = q[d].pop_front();
                        chk($sformatf("data%0d", d), int'(dout[d]), e.val);
                        chk($sformatf("latency%0d", d), ecnt - e.edge_n, 3);
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk);
            #1;
            valid_in = ~valid_in;
            data_in = 16'($urandom);
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("rst_vout", int'(vout[d]), 0);
                chk("rst_dout", int'(dout[d]), 0);
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        valid_in = 1'b0;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                chk("post_rst_vout", int'(vout[d]), 0);
                chk("post_rst_dout", int'(dout[d]), 0);
            end
        end
        send(100);
        send(-200);
        send(32767);
        send(-32768);
        drain();
        do_reset(2);
        send(16384);
        for (int i = 0; i < 17; i++) begin
            idle(3);
            send(0);
        end
        drain();
        do_reset(2);
        send(16384);
        idle(50);
        send(0);
        drain();
        do_reset(2);
        send(30000);
        drain();
        do_reset(2);
        send(1000);
        send(2000);
        send(3000);
        do_reset(3);
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) chk("mid_rst_quiet", int'(vout[d]), 0);
        end
        send(500);
        drain();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
